memshare_rqst_issuer: RTL

- Downstream consumer of the memShare request-address controller (operand/rebase generator) during SCU.memShare().
- Turns the controller's increment operand and DRC-rebased base address into a stream of read addresses for the message-passing buffer.
- Issues the stream under a valid/ready handshake and counts issued requests per SCU period.
- Signals completion to the SCU scheduler.

---
 rtl/memshare_rqst_issuer_if.sv | 20 ++
 rtl/memshare_rqst_issuer.sv | 117 +++++++++++
 2 files changed

// File: rtl/memshare_rqst_issuer_if.sv
// rtl/memshare_rqst_issuer_if.sv - read-address handshake bundle toward the message-passing buffer
interface memshare_rqst_issuer_if #(
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] rd_addr_o;
   logic                  rd_valid_o;
   logic                  rd_ready_i;

   modport master (
      output rd_addr_o,
      output rd_valid_o,
      input  rd_ready_i
   );

   modport slave (
      input  rd_addr_o,
      input  rd_valid_o,
      output rd_ready_i
   );
endinterface

// File: rtl/memshare_rqst_issuer.sv
// rtl/memshare_rqst_issuer.sv - issues memShare read-address stream and counts requests per SCU period
module memshare_rqst_issuer #(
   parameter int ADDR_WIDTH = 5,
   parameter int OPND_WIDTH = 4,
   parameter int MAX_RQST   = 8,
   parameter int CNT_WIDTH  = 4,
   parameter int ADDR_BASE  = 0
) (
   input  logic                     sys_clk,
   input  logic                     rstn,
   input  logic                     scu_begin_i,
   input  logic [CNT_WIDTH-1:0]     rqst_num_i,
   input  logic [OPND_WIDTH-1:0]    increment_operand_i,
   input  logic [ADDR_WIDTH-1:0]    drc_base_addr_i,
   input  logic                     rebase_i,
   memshare_rqst_issuer_if.master   rd_if,
   output logic [CNT_WIDTH-1:0]     issued_cnt_o,
   output logic                     busy_o,
   output logic                     done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0]  MAX_C  = CNT_WIDTH'(MAX_RQST);
   localparam logic [ADDR_WIDTH-1:0] BASE_C = ADDR_WIDTH'(ADDR_BASE);

   state_t                  state_q;
   logic [CNT_WIDTH-1:0]    cnt_lat_q;
   logic [CNT_WIDTH-1:0]    issued_cnt_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    valid_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    pend_q;

   logic [CNT_WIDTH-1:0]    rqst_sat_d;
   logic [CNT_WIDTH-1:0]    issued_cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_step_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic                    handshake;

   // Saturated request count, next counter value and next address for a handshake
   always_comb begin
      rqst_sat_d   = (rqst_num_i > MAX_C) ? MAX_C : rqst_num_i;
      issued_cnt_d = issued_cnt_q + CNT_WIDTH'(1);
      addr_step_d  = ADDR_WIDTH'(increment_operand_i);
      addr_d       = (rebase_i | pend_q) ? drc_base_addr_i : (addr_q + addr_step_d);
      handshake    = valid_q & rd_if.rd_ready_i;
   end

   // Period FSM with registered outputs; a new scu_begin_i always wins over a handshake
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         cnt_lat_q    <= '0;
         issued_cnt_q <= '0;
         addr_q       <= BASE_C;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pend_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (scu_begin_i) begin
            cnt_lat_q    <= rqst_sat_d;
            issued_cnt_q <= '0;
            addr_q       <= BASE_C;
            pend_q       <= 1'b0;
            if (rqst_sat_d == '0) begin
               state_q <= DONE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               state_q <= ISSUE;
               valid_q <= 1'b1;
               busy_q  <= 1'b1;
            end
         end else begin
            case (state_q)
               ISSUE: begin
                  if (handshake) begin
                     issued_cnt_q <= issued_cnt_d;
                     addr_q       <= addr_d;
                     pend_q       <= 1'b0;
                     if (issued_cnt_d == cnt_lat_q) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else if (rebase_i) begin
                     pend_q <= 1'b1;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign rd_if.rd_addr_o  = addr_q;
   assign rd_if.rd_valid_o = valid_q;
   assign issued_cnt_o     = issued_cnt_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;

endmodule
